// File: rtl/rename_maptable_multi.sv
// rename_maptable_multi
// Register alias table for the out-of-order core. Maps architectural
// registers to the ROB tag of their youngest in-flight producer, renames up
// to DISPATCH_W instructions per cycle with intra-group bypass, tracks
// producer readiness from the writeback buses, releases mappings at commit
// and drops every speculative mapping on flush.
//
// Ports:
//   clock, reset               rising-edge clock, async active-high reset
//   disp_valid/rd/rs1/rs2/tag  per-slot dispatch group (slot 0 is oldest)
//   wb_valid/wb_tag            writeback broadcasts
//   commit_valid/rd/tag        ROB head retirement
//   flush                      discard all speculative mappings
//   rs1_*/rs2_*                per-slot source lookup: tag, mapped, ready

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module rename_maptable_multi #(
   parameter int NUM_AREGS  = 32,
   parameter int AREG_LEN   = 5,
   parameter int TAG_LEN    = `ROB_TAG_LEN,
   parameter int DISPATCH_W = 2,
   parameter int WB_PORTS   = 2
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [DISPATCH_W-1:0]                disp_valid,
   input  logic [DISPATCH_W-1:0][AREG_LEN-1:0]  disp_rd,
   input  logic [DISPATCH_W-1:0][AREG_LEN-1:0]  disp_rs1,
   input  logic [DISPATCH_W-1:0][AREG_LEN-1:0]  disp_rs2,
   input  logic [DISPATCH_W-1:0][TAG_LEN-1:0]   disp_tag,
   input  logic [WB_PORTS-1:0]                  wb_valid,
   input  logic [WB_PORTS-1:0][TAG_LEN-1:0]     wb_tag,
   input  logic                                 commit_valid,
   input  logic [AREG_LEN-1:0]                  commit_rd,
   input  logic [TAG_LEN-1:0]                   commit_tag,
   input  logic                                 flush,
   output logic [DISPATCH_W-1:0][TAG_LEN-1:0]   rs1_tag,
   output logic [DISPATCH_W-1:0][TAG_LEN-1:0]   rs2_tag,
   output logic [DISPATCH_W-1:0]                rs1_mapped,
   output logic [DISPATCH_W-1:0]                rs2_mapped,
   output logic [DISPATCH_W-1:0]                rs1_ready,
   output logic [DISPATCH_W-1:0]                rs2_ready
);

   typedef struct packed {
      logic               mapped;
      logic               ready;
      logic [TAG_LEN-1:0] tag;
   } lookup_t;

   logic               ent_valid [NUM_AREGS];
   logic               ent_ready [NUM_AREGS];
   logic [TAG_LEN-1:0] ent_tag   [NUM_AREGS];

   // Index 0 = rs1, 1 = rs2.
   lookup_t res [2][DISPATCH_W];

   function automatic logic wb_hit(input logic [TAG_LEN-1:0]               t,
                                   input logic [WB_PORTS-1:0]              v,
                                   input logic [WB_PORTS-1:0][TAG_LEN-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < WB_PORTS; p++)
         if (v[p] && tags[p] == t) hit = 1'b1;
      return hit;
   endfunction

   // Source lookup: r0, then youngest older slot in the group, then the
   // table (with same-cycle writeback forwarding), else the arch regfile.
   always_comb begin
      logic [AREG_LEN-1:0] src;
      logic                byp_hit;
      logic [TAG_LEN-1:0]  byp_tag;
      // NOTE: every variable gets a value before any branch so no path can
      // leave it holding an old value, which is what would infer a latch.
      src     = '0;
      byp_hit = 1'b0;
      byp_tag = '0;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < DISPATCH_W; j++) begin
            src     = (k == 0) ? disp_rs1[j] : disp_rs2[j];
            byp_hit = 1'b0;
            byp_tag = '0;
            // Ascending scan so the youngest older producer is kept.
            for (int i = 0; i < j; i++) begin
               if (disp_valid[i] && disp_rd[i] == src) begin
                  byp_hit = 1'b1;
                  byp_tag = disp_tag[i];
               end
            end
            res[k][j] = '{mapped: 1'b0, ready: 1'b1, tag: '0};
            if (src == '0) begin
               res[k][j] = '{mapped: 1'b0, ready: 1'b1, tag: '0};
            end else if (byp_hit) begin
               // A tag allocated this cycle cannot already be written back.
               res[k][j] = '{mapped: 1'b1, ready: 1'b0, tag: byp_tag};
            end else if (ent_valid[src]) begin
               res[k][j] = '{mapped: 1'b1,
                             ready:  ent_ready[src] | wb_hit(ent_tag[src], wb_valid, wb_tag),
                             tag:    ent_tag[src]};
            end
         end
      end
   end

   always_comb begin
      for (int j = 0; j < DISPATCH_W; j++) begin
         rs1_tag[j]    = res[0][j].tag;
         rs1_mapped[j] = res[0][j].mapped;
         rs1_ready[j]  = res[0][j].ready;
         rs2_tag[j]    = res[1][j].tag;
         rs2_mapped[j] = res[1][j].mapped;
         rs2_ready[j]  = res[1][j].ready;
      end
   end

   // Entry 0 is never written after reset, so it stays empty forever.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the table is architecturally visible right after reset, so
         // every entry is cleared rather than left as uninitialised storage.
         for (int r = 0; r < NUM_AREGS; r++) begin
            ent_valid[r] <= 1'b0;
            ent_ready[r] <= 1'b0;
            ent_tag[r]   <= '0;
         end
      end else if (flush) begin
         // Tags are left in place; with valid cleared they are never used.
         for (int r = 1; r < NUM_AREGS; r++) begin
            ent_valid[r] <= 1'b0;
            ent_ready[r] <= 1'b0;
         end
      end else begin
         for (int r = 1; r < NUM_AREGS; r++) begin
            // NOTE: these non-blocking writes are ordered lowest to highest
            // priority; the last one to the same entry in this pass wins.
            if (ent_valid[r] && wb_hit(ent_tag[r], wb_valid, wb_tag))
               ent_ready[r] <= 1'b1;
            if (commit_valid && commit_rd == AREG_LEN'(r) &&
                ent_valid[r] && ent_tag[r] == commit_tag) begin
               ent_valid[r] <= 1'b0;
               ent_ready[r] <= 1'b0;
            end
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (disp_valid[i] && disp_rd[i] == AREG_LEN'(r)) begin
                  ent_valid[r] <= 1'b1;
                  ent_tag[r]   <= disp_tag[i];
                  ent_ready[r] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rename_maptable_multi.sv
// Self-checking bench for rename_maptable_multi: directed scenarios for the
// documented corner cases followed by randomized traffic, all compared
// against a behavioural map model held in the bench.

module tb_rename_maptable_multi;

   localparam int NA = 32;
   localparam int AL = 5;
   localparam int TL = 5;
   localparam int DW = 2;
   localparam int WP = 2;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic [DW-1:0]            disp_valid;
   logic [DW-1:0][AL-1:0]    disp_rd, disp_rs1, disp_rs2;
   logic [DW-1:0][TL-1:0]    disp_tag;
   logic [WP-1:0]            wb_valid;
   logic [WP-1:0][TL-1:0]    wb_tag;
   logic                     commit_valid;
   logic [AL-1:0]            commit_rd;
   logic [TL-1:0]            commit_tag;
   logic                     flush;
   logic [DW-1:0][TL-1:0]    rs1_tag, rs2_tag;
   logic [DW-1:0]            rs1_mapped, rs2_mapped, rs1_ready, rs2_ready;

   rename_maptable_multi #(
      .NUM_AREGS(NA), .AREG_LEN(AL), .TAG_LEN(TL), .DISPATCH_W(DW), .WB_PORTS(WP)
   ) dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_rs1(disp_rs1),
      .disp_rs2(disp_rs2), .disp_tag(disp_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .flush(flush),
      .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
      .rs1_mapped(rs1_mapped), .rs2_mapped(rs2_mapped),
      .rs1_ready(rs1_ready), .rs2_ready(rs2_ready)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: which registers hold a live mapping, to which tag,
   // and whether that producer has written back.
   bit m_valid [NA];
   int m_tag   [NA];
   bit m_ready [NA];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic bit wb_any(input int t);
      for (int p = 0; p < WP; p++)
         if (wb_valid[p] && int'(wb_tag[p]) == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NA; r++) begin
         m_valid[r] = 1'b0; m_tag[r] = 0; m_ready[r] = 1'b0;
      end
   endtask

   task automatic model_lookup(input int j, input int src,
                               output bit mapped, output int tag, output bit ready);
      mapped = 1'b0; tag = 0; ready = 1'b1;
      if (src == 0) return;
      for (int i = j - 1; i >= 0; i--) begin
         if (disp_valid[i] && int'(disp_rd[i]) == src) begin
            mapped = 1'b1; tag = int'(disp_tag[i]); ready = 1'b0;
            return;
         end
      end
      if (m_valid[src]) begin
         mapped = 1'b1; tag = m_tag[src];
         ready  = m_ready[src] || wb_any(m_tag[src]);
      end
   endtask

   task automatic check_lookups();
      bit em, er;
      int et, src;
      for (int j = 0; j < DW; j++) begin
         for (int k = 0; k < 2; k++) begin
            src = (k == 0) ? int'(disp_rs1[j]) : int'(disp_rs2[j]);
            model_lookup(j, src, em, et, er);
            if (k == 0) begin
               check($sformatf("s%0d_rs1(r%0d)_mapped", j, src), 32'(rs1_mapped[j]), 32'(em));
               check($sformatf("s%0d_rs1(r%0d)_tag", j, src),    32'(rs1_tag[j]),    32'(et));
               check($sformatf("s%0d_rs1(r%0d)_ready", j, src),  32'(rs1_ready[j]),  32'(er));
            end else begin
               check($sformatf("s%0d_rs2(r%0d)_mapped", j, src), 32'(rs2_mapped[j]), 32'(em));
               check($sformatf("s%0d_rs2(r%0d)_tag", j, src),    32'(rs2_tag[j]),    32'(et));
               check($sformatf("s%0d_rs2(r%0d)_ready", j, src),  32'(rs2_ready[j]),  32'(er));
            end
         end
      end
   endtask

   // Next map state from the current inputs: writeback, then commit, then
   // dispatch in slot order; flush empties the map.
   task automatic model_update();
      bit n_valid [NA];
      int n_tag   [NA];
      bit n_ready [NA];
      n_valid = m_valid; n_tag = m_tag; n_ready = m_ready;
      if (flush) begin
         for (int r = 0; r < NA; r++) begin n_valid[r] = 1'b0; n_ready[r] = 1'b0; end
      end else begin
         for (int r = 1; r < NA; r++)
            if (m_valid[r] && wb_any(m_tag[r])) n_ready[r] = 1'b1;
         if (commit_valid && commit_rd != 0 && m_valid[commit_rd] &&
             m_tag[commit_rd] == int'(commit_tag)) begin
            n_valid[commit_rd] = 1'b0; n_ready[commit_rd] = 1'b0;
         end
         for (int i = 0; i < DW; i++) begin
            if (disp_valid[i] && disp_rd[i] != 0) begin
               n_valid[disp_rd[i]] = 1'b1;
               n_tag[disp_rd[i]]   = int'(disp_tag[i]);
               n_ready[disp_rd[i]] = 1'b0;
            end
         end
      end
      m_valid = n_valid; m_tag = n_tag; m_ready = n_ready;
   endtask

   task automatic clear_inputs();
      disp_valid = '0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0; disp_tag = '0;
      wb_valid = '0; wb_tag = '0;
      commit_valid = 1'b0; commit_rd = '0; commit_tag = '0;
      flush = 1'b0;
   endtask

   // Inputs are already set; check lookups mid-cycle, then take the edge.
   task automatic do_cycle();
      @(negedge clock);
      check_lookups();
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic disp(input int slot, input int rd, input int tag);
      disp_valid[slot] = 1'b1;
      disp_rd[slot]    = AL'(rd);
      disp_tag[slot]   = TL'(tag);
   endtask

   initial begin
      clear_inputs();
      model_reset();
      #2;
      check_lookups();
      @(posedge clock); #1;
      reset = 1'b0;

      // Reset mid-traffic.
      disp(0, 5, 3);
      do_cycle();
      clear_inputs();
      disp_rs1[0] = 5;
      #1;
      check("pre_rst_r5_tag", 32'(rs1_tag[0]), 32'd3);
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_r5_mapped", 32'(rs1_mapped[0]), 32'd0);
      check("rst_r5_ready",  32'(rs1_ready[0]),  32'd1);
      check("rst_r5_tag",    32'(rs1_tag[0]),    32'd0);
      check_lookups();
      @(posedge clock); #1;
      reset = 1'b0;

      // Intra-group bypass.
      clear_inputs();
      disp(0, 7, 4);
      disp_rs1[1] = 7; disp_rs2[1] = 7;
      #1;
      check("byp_s1_rs1_tag",   32'(rs1_tag[1]),    32'd4);
      check("byp_s1_rs2_mapped", 32'(rs2_mapped[1]), 32'd1);
      check("byp_s1_rs2_ready", 32'(rs2_ready[1]),  32'd0);
      do_cycle();
      clear_inputs();
      disp_rs1[0] = 7;
      do_cycle();

      // Writeback forwarding.
      clear_inputs();
      disp(0, 9, 6);
      do_cycle();
      clear_inputs();
      disp_rs1[0] = 9; wb_valid[1] = 1'b1; wb_tag[1] = 6;
      #1;
      check("wbfwd_r9_ready", 32'(rs1_ready[0]), 32'd1);
      do_cycle();
      clear_inputs();
      disp_rs1[0] = 9;
      #1;
      check("wbfwd_r9_ready_next", 32'(rs1_ready[0]), 32'd1);
      do_cycle();

      // Stale commit, then commit colliding with a re-dispatch.
      clear_inputs(); disp(0, 2, 1); do_cycle();
      clear_inputs(); disp(0, 2, 8); do_cycle();
      clear_inputs(); commit_valid = 1'b1; commit_rd = 2; commit_tag = 1; do_cycle();
      clear_inputs(); disp_rs1[0] = 2;
      #1;
      check("stale_r2_tag", 32'(rs1_tag[0]), 32'd8);
      do_cycle();
      clear_inputs(); commit_valid = 1'b1; commit_rd = 2; commit_tag = 8;
      disp(0, 2, 10); do_cycle();
      clear_inputs(); disp_rs1[0] = 2;
      #1;
      check("coll_r2_tag",   32'(rs1_tag[0]),   32'd10);
      check("coll_r2_ready", 32'(rs1_ready[0]), 32'd0);
      do_cycle();

      // Same-rd dual dispatch.
      clear_inputs(); disp(0, 3, 2); disp(1, 3, 5); do_cycle();
      clear_inputs(); disp_rs1[0] = 3;
      #1;
      check("dual_r3_tag", 32'(rs1_tag[0]), 32'd5);
      do_cycle();

      // Flush with a concurrent dispatch.
      clear_inputs(); disp(0, 1, 11); disp(1, 2, 12); do_cycle();
      clear_inputs(); disp(0, 3, 13); disp(1, 4, 14); do_cycle();
      clear_inputs(); flush = 1'b1; disp(0, 6, 15); do_cycle();
      clear_inputs();
      disp_rs1[0] = 1; disp_rs2[0] = 2; disp_rs1[1] = 3; disp_rs2[1] = 4;
      #1;
      check("flush_r4_mapped", 32'(rs2_mapped[1]), 32'd0);
      do_cycle();
      clear_inputs(); disp_rs1[0] = 5; disp_rs2[0] = 6;
      #1;
      check("flush_r6_mapped", 32'(rs2_mapped[0]), 32'd0);
      check("flush_r6_ready",  32'(rs2_ready[0]),  32'd1);
      do_cycle();

      // Randomized traffic over a small register window to force collisions.
      for (int n = 0; n < 3000; n++) begin
         int cr;
         clear_inputs();
         for (int i = 0; i < DW; i++) begin
            disp_valid[i] = 1'($urandom_range(0, 1));
            disp_rd[i]    = AL'($urandom_range(0, 7));
            disp_rs1[i]   = AL'($urandom_range(0, 7));
            disp_rs2[i]   = AL'($urandom_range(0, 7));
            disp_tag[i]   = TL'($urandom);
         end
         for (int p = 0; p < WP; p++) begin
            cr = $urandom_range(0, 7);
            wb_valid[p] = 1'($urandom_range(0, 1));
            wb_tag[p]   = ($urandom_range(0, 3) != 0) ? TL'(m_tag[cr]) : TL'($urandom);
         end
         cr = $urandom_range(0, 7);
         commit_valid = 1'($urandom_range(0, 1));
         commit_rd    = AL'(cr);
         commit_tag   = ($urandom_range(0, 3) != 0) ? TL'(m_tag[cr]) : TL'($urandom);
         flush        = ($urandom_range(0, 49) == 0);
         do_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
